bcd_stopwatch: RTL and testbench
================================

# bcd_stopwatch

Parametrised BCD elapsed-time counter for the typing-test system, generalising the fixed three-digit deciseconds/seconds/decaseconds timer. It provides DIGITS decimal digits, a configurable tick rate, start/stop/clear control, and a choice of wrap or saturate on overflow. An optional lap-capture register can be compiled in. Its digit bus feeds `hexdigit` instances directly, one nibble per display.

## Interface
- `CLK_HZ`, 50_000_000: input clock frequency.
- `TICK_HZ`, 10: count rate. `DIV = CLK_HZ/TICK_HZ` must be an integer ≥ 2; elaborate-time error otherwise.
- `DIGITS`, 3: number of BCD digits, 1..8.
- `SAT`, 0: overflow mode.
  - 0: wrap to all-zero.
  - 1: saturate at all-nines and stop.
- `clk`  in  1  system clock (CLOCK_50 at top).
- `rst`  in  1  reset; one clock, asynchronous, active-low.
- `start`  in  1  level sampled each cycle; begin or resume counting.
- `stop`  in  1  pause counting.
- `clear`  in  1  return to zero/idle.
- `lap`  in  1  capture current count (LAP_EN only).
- `digits`  out  4*DIGITS  BCD count; digit 0 (least significant) in [3:0].
- `lap_digits`  out  4*DIGITS  captured count.
- `running`  out  1  high in RUN state.
- `tick`  out  1  one-cycle pulse in the cycle `digits` shows a new value.
- `overflow`  out  1  sticky; set when the count passes all-nines.

## Operation
- States and transitions:
  - IDLE: `start` → RUN.
  - RUN: `stop` → PAUSE.
  - PAUSE: `start` → RUN.
  - DONE: exits only via `clear`.
- Priority each cycle: `clear` > `stop` > `start`.
  - `clear` in any state: next state IDLE; digits, prescaler, `overflow` and `lap_digits` all go to 0.
- `stop` in IDLE and `start` in DONE are ignored. `start` while in RUN has no effect.
- Prescaler:
  - Width `$clog2(DIV)`.
  - Increments only on cycles where state is RUN; wraps DIV-1 → 0, and that wrap increments the count.
  - Holds its value in PAUSE, so a resumed partial period completes rather than restarting.
  - Zeroed on IDLE entry.
- BCD increment:
  - Digit k increments when all lower digits are 9; a digit at 9 rolls to 0.
  - Digits are never outside 0..9.
- Overflow (increment while all digits are 9):
  - SAT=0: digits → 0, `overflow` ← 1, stay in RUN.
  - SAT=1: digits hold at 9s, `overflow` ← 1, state → DONE.
- Increment and `stop` on the same edge: the increment is applied, then the state becomes PAUSE.
- Increment and `clear` on the same edge: `clear` wins.

## Timing
- Reset values: `digits`=0, `lap_digits`=0, `running`=0, `tick`=0, `overflow`=0; state IDLE, prescaler 0.
- `start` sampled at edge n → `running`=1 after edge n. The first `tick` and first increment occur DIV cycles after `running` rises.
- `stop` sampled at edge n → `running`=0 after edge n; no increment occurs after edge n.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Inputs are synchronous to `clk`; debouncing and synchronisation are done upstream.

## Configuration
- Macro: `BCD_STOPWATCH_LAP_EN`.
- Defined:
  - `lap` sampled at edge n → `lap_digits` equals the `digits` value held before edge n, visible after edge n.
  - Counting is unaffected.
  - `lap` and `clear` together: `clear` wins, `lap_digits`=0.
- Undefined: `lap` is ignored, `lap_digits` is tied to 0, and no capture register is built.

## Test plan
Bench parameters unless stated: CLK_HZ=100, TICK_HZ=10 (DIV=10), DIGITS=2.
- Reset: assert `rst`=0 mid-run with digits=8'h47 → all outputs 0 immediately (asynchronously); after release, `start` is required to resume.
- Basic count: pulse `start`, run 120 cycles after `running` rises → `digits`=8'h12, exactly 12 `tick` pulses, all digits valid BCD.
- Pause and resume:
  - Pulse `stop` when the prescaler is 4, wait 50 cycles → `digits` unchanged.
  - Pulse `start` → next `tick` arrives 6 cycles after `running` rises.
- Overflow:
  - SAT=0, run 100 ticks → `digits`=8'h00, `overflow`=1, `running`=1.
  - SAT=1, same run → `digits`=8'h99, `running`=0, `overflow`=1; `start` is then ignored and `clear` returns to 8'h00.
- Simultaneous controls:
  - `start`+`stop` in RUN → PAUSE.
  - `clear`+`start` in PAUSE → IDLE with `digits`=0.
  - `stop` on a prescaler-wrap edge → increment applied, then paused.
- Lap:
  - With `BCD_STOPWATCH_LAP_EN`: `lap` at `digits`=8'h37 → `lap_digits`=8'h37 next cycle, `digits` keeps counting.
  - Without the macro: `lap_digits` stays 0.

Source files
------------

// File: rtl/bcd_stopwatch.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_stopwatch
//  Description : Parametrised BCD elapsed-time counter with start/stop/clear
//                control and a choice of wrap or saturate on overflow.
//                A prescaler divides clk down to TICK_HZ. Each prescaler wrap
//                advances a DIGITS-wide BCD count.
//  Option      : define BCD_STOPWATCH_LAP_EN to build the lap-capture
//                register. Without it, lap is ignored and lap_digits is 0.
//  Ports       : clk        - system clock
//                rst        - asynchronous active-low reset
//                start      - begin / resume counting
//                stop       - pause counting
//                clear      - return to zero / idle (highest priority)
//                lap        - capture current count (lap option only)
//                digits     - BCD count, digit 0 in [3:0]
//                lap_digits - captured count
//                running    - high while counting
//                tick       - one-cycle pulse when digits changes
//                overflow   - sticky, set when the count passes all-nines
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_stopwatch #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 10,
    parameter int DIGITS  = 3,
    parameter int SAT     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   digits,
    output logic [4*DIGITS-1:0]   lap_digits,
    output logic                  running,
    output logic                  tick,
    output logic                  overflow
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW  = 4 * DIGITS;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    generate
        if ((DIV < 2) || ((CLK_HZ % TICK_HZ) != 0)) begin : g_bad_div
            $error("bcd_stopwatch: CLK_HZ/TICK_HZ must be an integer >= 2");
        end
        if ((DIGITS < 1) || (DIGITS > 8)) begin : g_bad_digits
            $error("bcd_stopwatch: DIGITS must be in 1..8");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [DW-1:0]   digits_q, digits_d;
    logic            tick_q, tick_d;
    logic            ovf_q, ovf_d;
    logic            running_q, running_d;

    logic [DW-1:0]   digits_inc;
    logic            inc_carry;
    logic            all_nines;
    logic            presc_wrap;

    // Ripple BCD increment: a digit advances only when every lower digit is
    // 9. A carry out of the top digit means the count was all-nines.
    always_comb begin
        inc_carry  = 1'b1;
        digits_inc = digits_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (inc_carry) begin
                if (digits_q[4*k +: 4] == 4'd9) begin
                    digits_inc[4*k +: 4] = 4'd0;
                end else begin
                    digits_inc[4*k +: 4] = digits_q[4*k +: 4] + 4'd1;
                    inc_carry            = 1'b0;
                end
            end
        end
        all_nines = inc_carry;
    end

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        digits_d   = digits_q;
        ovf_d      = ovf_q;
        tick_d     = 1'b0;
        presc_wrap = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

        if (clear) begin
            state_d  = ST_IDLE;
            presc_d  = '0;
            digits_d = '0;
            ovf_d    = 1'b0;
        end else begin
            // The prescaler runs only in RUN, so a pause keeps the partial period.
            if (state_q == ST_RUN) begin
                presc_d = presc_wrap ? '0 : presc_q + 1'b1;
            end

            // stop outranks start. A stop in IDLE still suppresses start.
            case (state_q)
                ST_IDLE:  if (start && !stop) state_d = ST_RUN;
                ST_RUN:   if (stop)           state_d = ST_PAUSE;
                ST_PAUSE: if (start && !stop) state_d = ST_RUN;
                default:  state_d = state_q;
            endcase

            // The increment lands on the same edge as a stop. Saturation
            // overrides the pause because DONE can only be left via clear.
            if (presc_wrap) begin
                if (!all_nines) begin
                    digits_d = digits_inc;
                    tick_d   = 1'b1;
                end else if (SAT != 0) begin
                    ovf_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    digits_d = digits_inc;
                    ovf_d    = 1'b1;
                    tick_d   = 1'b1;
                end
            end
        end

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            digits_q  <= '0;
            tick_q    <= 1'b0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            digits_q  <= digits_d;
            tick_q    <= tick_d;
            ovf_q     <= ovf_d;
            running_q <= running_d;
        end
    end

    assign digits   = digits_q;
    assign running  = running_q;
    assign tick     = tick_q;
    assign overflow = ovf_q;

`ifdef BCD_STOPWATCH_LAP_EN
    logic [DW-1:0] lap_q, lap_d;

    // Captures the count held before the edge, not the value being written.
    always_comb begin
        lap_d = lap_q;
        if (clear) begin
            lap_d = '0;
        end else if (lap) begin
            lap_d = digits_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_q <= '0;
        end else begin
            lap_q <= lap_d;
        end
    end

    assign lap_digits = lap_q;
`else
    logic lap_unused;
    assign lap_unused = lap;
    assign lap_digits = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd_stopwatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_stopwatch
//  Description : Self-checking bench for bcd_stopwatch. It runs a wrapping
//                instance (index 0) and a saturating instance (index 1) from
//                the same inputs. The reference model treats the count as a
//                plain integer and converts it to BCD for comparison.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_stopwatch;

    localparam int CLK_HZ  = 100;
    localparam int TICK_HZ = 10;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int MAXC    = 99;

    localparam int IDLE  = 0;
    localparam int RUN   = 1;
    localparam int PAUSE = 2;
    localparam int DONE  = 3;

`ifdef BCD_STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    logic start, stop, clear, lap;

    logic [7:0] dig     [2];
    logic [7:0] lapd    [2];
    logic       run_o   [2];
    logic       tick_o  [2];
    logic       ovf_o   [2];

    int n_tests;
    int n_fail;

    // Reference model state
    int m_state [2];
    int m_pre   [2];
    int m_cnt   [2];
    int m_lap   [2];
    bit m_ovf   [2];
    bit m_tick  [2];

    bcd_stopwatch #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DIGITS(2), .SAT(0)) u_dut_wrap (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .digits(dig[0]), .lap_digits(lapd[0]), .running(run_o[0]),
        .tick(tick_o[0]), .overflow(ovf_o[0])
    );

    bcd_stopwatch #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DIGITS(2), .SAT(1)) u_dut_sat (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .digits(dig[1]), .lap_digits(lapd[1]), .running(run_o[1]),
        .tick(tick_o[1]), .overflow(ovf_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[3:0] = 4'(v % 10);
        r[7:4] = 4'((v / 10) % 10);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = IDLE; m_pre[i] = 0; m_cnt[i] = 0;
            m_lap[i] = 0; m_ovf[i] = 1'b0; m_tick[i] = 1'b0;
        end
    endtask

    // One active edge of the spec's behaviour, applied with the inputs as sampled.
    task automatic model_edge();
        int  ns;
        bit  inc;
        for (int i = 0; i < 2; i++) begin
            m_tick[i] = 1'b0;
            if (clear) begin
                m_state[i] = IDLE; m_pre[i] = 0; m_cnt[i] = 0;
                m_lap[i] = 0; m_ovf[i] = 1'b0;
            end else begin
                inc = (m_state[i] == RUN) && (m_pre[i] == DIV - 1);
                if (m_state[i] == RUN) m_pre[i] = (m_pre[i] + 1) % DIV;
                ns = m_state[i];
                if (stop) begin
                    if (m_state[i] == RUN) ns = PAUSE;
                end else if (start && (m_state[i] == IDLE || m_state[i] == PAUSE)) begin
                    ns = RUN;
                end
                if (LAP_EN && lap) m_lap[i] = m_cnt[i];
                if (inc) begin
                    if (m_cnt[i] < MAXC) begin
                        m_cnt[i]  = m_cnt[i] + 1;
                        m_tick[i] = 1'b1;
                    end else begin
                        m_ovf[i] = 1'b1;
                        if (i == 1) begin
                            ns = DONE;
                        end else begin
                            m_cnt[i]  = 0;
                            m_tick[i] = 1'b1;
                        end
                    end
                end
                m_state[i] = ns;
            end
        end
    endtask

    // Advance one clock: inputs are stable across the posedge, outputs are
    // observed at the following negedge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear = 1'b1; cycle(); clear = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({dig[i], lapd[i], run_o[i], tick_o[i], ovf_o[i]} !== 19'd0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got dig=%h lap=%h run=%b tick=%b ovf=%b, want all 0",
                         i, dig[i], lapd[i], run_o[i], tick_o[i], ovf_o[i]);
            end
        end
        rst = 1'b1;
        cycle();

        // Asynchronous reset in the middle of a run at 47.
        pulse_start();
        repeat (470) cycle();
        n_tests++;
        if (dig[0] !== 8'h47 || dig[0] !== to_bcd(m_cnt[0])) begin
            n_fail++;
            $display("FAIL pre_reset_count: got %h, want 47", dig[0]);
        end
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({dig[i], lapd[i], run_o[i], tick_o[i], ovf_o[i]} !== 19'd0) begin
                n_fail++;
                $display("FAIL async_reset[%0d]: got dig=%h lap=%h run=%b tick=%b ovf=%b, want all 0",
                         i, dig[i], lapd[i], run_o[i], tick_o[i], ovf_o[i]);
            end
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (25) cycle();
        n_tests++;
        if (run_o[0] !== 1'b0 || dig[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL post_reset_idle: got run=%b dig=%h, want run=0 dig=00", run_o[0], dig[0]);
        end
    endtask

    task automatic test_basic_count();
        int tc;
        bit bad_bcd;
        pulse_clear();
        pulse_start();
        n_tests++;
        if (run_o[0] !== 1'b1 || run_o[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL start_running: got %b/%b, want 1/1", run_o[0], run_o[1]);
        end
        tc = 0;
        bad_bcd = 1'b0;
        repeat (120) begin
            cycle();
            if (tick_o[0] === 1'b1) tc++;
            if (dig[0][3:0] > 4'd9 || dig[0][7:4] > 4'd9) bad_bcd = 1'b1;
        end
        n_tests++;
        if (dig[0] !== 8'h12 || dig[1] !== to_bcd(m_cnt[1])) begin
            n_fail++;
            $display("FAIL basic_count: got %h/%h, want 12/%h", dig[0], dig[1], to_bcd(m_cnt[1]));
        end
        n_tests++;
        if (tc !== 12) begin
            n_fail++;
            $display("FAIL basic_tick_count: got %0d, want 12", tc);
        end
        n_tests++;
        if (bad_bcd !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_bcd_valid: got invalid digit seen, want none");
        end
    endtask

    task automatic test_pause_resume();
        logic [7:0] held;
        int n, j, want;
        for (int round = 0; round < 3; round++) begin
            pulse_clear();
            pulse_start();
            j = (round == 0) ? 13 : int'($urandom_range(1, 35));
            repeat (j) cycle();
            stop = 1'b1; cycle(); stop = 1'b0;
            n_tests++;
            if (run_o[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_running: got %b, want 0", run_o[0]);
            end
            held = dig[0];
            repeat (50) cycle();
            n_tests++;
            if (dig[0] !== held || dig[0] !== to_bcd(m_cnt[0]) || (round == 0 && dig[0] !== 8'h01)) begin
                n_fail++;
                $display("FAIL pause_hold: got %h, want %h", dig[0], to_bcd(m_cnt[0]));
            end
            want = DIV - m_pre[0];
            pulse_start();
            n = 0;
            while (tick_o[0] !== 1'b1 && n < 40) begin
                cycle();
                n++;
            end
            n_tests++;
            if (n !== want || (round == 0 && n !== 6)) begin
                n_fail++;
                $display("FAIL resume_latency: got %0d cycles, want %0d", n, want);
            end
        end
    endtask

    task automatic test_overflow();
        pulse_clear();
        pulse_start();
        repeat (1000) cycle();
        n_tests++;
        if (dig[0] !== 8'h00 || ovf_o[0] !== 1'b1 || run_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_wrap: got dig=%h ovf=%b run=%b, want 00/1/1", dig[0], ovf_o[0], run_o[0]);
        end
        n_tests++;
        if (dig[1] !== 8'h99 || ovf_o[1] !== 1'b1 || run_o[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_sat: got dig=%h ovf=%b run=%b, want 99/1/0", dig[1], ovf_o[1], run_o[1]);
        end
        pulse_start();
        repeat (15) cycle();
        n_tests++;
        if (dig[1] !== 8'h99 || run_o[1] !== 1'b0 || ovf_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL done_ignores_start: got dig=%h run=%b wrap_ovf=%b, want 99/0/1", dig[1], run_o[1], ovf_o[0]);
        end
        pulse_clear();
        n_tests++;
        if (dig[1] !== 8'h00 || ovf_o[1] !== 1'b0 || dig[0] !== 8'h00 || ovf_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clear: got %h/%b %h/%b, want 00/0 00/0", dig[0], ovf_o[0], dig[1], ovf_o[1]);
        end
    endtask

    task automatic test_simultaneous();
        pulse_clear();
        pulse_start();
        repeat (3) cycle();
        start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
        n_tests++;
        if (run_o[0] !== 1'b0 || m_state[0] != PAUSE) begin
            n_fail++;
            $display("FAIL start_stop_in_run: got run=%b, want 0", run_o[0]);
        end
        clear = 1'b1; start = 1'b1; cycle(); clear = 1'b0; start = 1'b0;
        n_tests++;
        if (run_o[0] !== 1'b0 || dig[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL clear_start_in_pause: got run=%b dig=%h, want 0/00", run_o[0], dig[0]);
        end
        pulse_start();
        repeat (DIV - 1) cycle();
        stop = 1'b1; cycle(); stop = 1'b0;
        n_tests++;
        if (dig[0] !== 8'h01 || tick_o[0] !== 1'b1 || run_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_on_wrap: got dig=%h tick=%b run=%b, want 01/1/0", dig[0], tick_o[0], run_o[0]);
        end
        repeat (20) cycle();
        n_tests++;
        if (dig[0] !== 8'h01) begin
            n_fail++;
            $display("FAIL stop_on_wrap_hold: got %h, want 01", dig[0]);
        end
    endtask

    task automatic test_lap();
        logic [7:0] want_lap;
        want_lap = LAP_EN ? 8'h37 : 8'h00;
        pulse_clear();
        pulse_start();
        repeat (370) cycle();
        n_tests++;
        if (dig[0] !== 8'h37) begin
            n_fail++;
            $display("FAIL lap_precount: got %h, want 37", dig[0]);
        end
        lap = 1'b1; cycle(); lap = 1'b0;
        n_tests++;
        if (lapd[0] !== want_lap || lapd[1] !== want_lap) begin
            n_fail++;
            $display("FAIL lap_capture: got %h/%h, want %h", lapd[0], lapd[1], want_lap);
        end
        repeat (10) cycle();
        n_tests++;
        if (dig[0] !== 8'h38 || lapd[0] !== want_lap) begin
            n_fail++;
            $display("FAIL lap_keeps_counting: got dig=%h lap=%h, want 38/%h", dig[0], lapd[0], want_lap);
        end
        lap = 1'b1; clear = 1'b1; cycle(); lap = 1'b0; clear = 1'b0;
        n_tests++;
        if (lapd[0] !== 8'h00 || dig[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL lap_clear: got lap=%h dig=%h, want 00/00", lapd[0], dig[0]);
        end
    endtask

    task automatic test_random();
        pulse_clear();
        for (int c = 0; c < 4000; c++) begin
            start = ($urandom_range(0, 14) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            clear = ($urandom_range(0, 399) == 0);
            lap   = ($urandom_range(0, 29) == 0);
            cycle();
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (dig[i] !== to_bcd(m_cnt[i]) || run_o[i] !== (m_state[i] == RUN) ||
                    tick_o[i] !== m_tick[i] || ovf_o[i] !== m_ovf[i] || lapd[i] !== to_bcd(m_lap[i])) begin
                    n_fail++;
                    $display("FAIL random[%0d] cyc %0d: got dig=%h run=%b tick=%b ovf=%b lap=%h, want %h/%b/%b/%b/%h",
                             i, c, dig[i], run_o[i], tick_o[i], ovf_o[i], lapd[i],
                             to_bcd(m_cnt[i]), (m_state[i] == RUN), m_tick[i], m_ovf[i], to_bcd(m_lap[i]));
                end
            end
        end
        start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic_count();
        test_pause_resume();
        test_overflow();
        test_simultaneous();
        test_lap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
